// File: rtl/rewind_fifo_pkg.sv
// Shared helpers for the rewind FIFO: depth derivation and modular pointer arithmetic.
package rewind_fifo_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned DEFAULT_AW    = 9;

  function automatic int unsigned fifo_depth(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

  // Pointers carry one extra MSB, so the distance is taken modulo 2**(aw+1).
  function automatic logic [31:0] fifo_count(input logic [31:0] wr,
                                             input logic [31:0] rd,
                                             input int unsigned aw);
    logic [31:0] mask;
    mask = (32'd1 << (aw + 1)) - 32'd1;
    return (wr - rd) & mask;
  endfunction

endpackage

// File: rtl/rewind_fifo_if.sv
// Bundle of the FIFO's control, data and status signals; slave is the FIFO side.
interface rewind_fifo_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = 9
) ();

  logic             sclr;
  logic             wrreq;
  logic [WIDTH-1:0] data;
  logic             rdreq;
  logic [WIDTH-1:0] q;
  logic             empty;
  logic             full;
  logic             almost_empty;
  logic             almost_full;
  logic [AW:0]      usedw;
  logic             mark;
  logic             rewind;
  logic             release_mark;
  logic             mark_valid;
  logic             overflow;
  logic             underflow;
  logic             clr_err;

  modport master (
    output sclr, wrreq, data, rdreq, mark, rewind, release_mark, clr_err,
    input  q, empty, full, almost_empty, almost_full, usedw,
           mark_valid, overflow, underflow
  );

  modport slave (
    input  sclr, wrreq, data, rdreq, mark, rewind, release_mark, clr_err,
    output q, empty, full, almost_empty, almost_full, usedw,
           mark_valid, overflow, underflow
  );

endinterface

// File: rtl/rewind_fifo_ram.sv
// Simple dual-port storage: one clocked write port, one asynchronous read port.
module rewind_fifo_ram #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = 9
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [2**AW];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/rewind_fifo.sv
// Show-ahead FIFO with occupancy thresholds, sticky error flags and a mark/rewind
// read pointer so a block can be replayed without re-fetching it.
module rewind_fifo
  import rewind_fifo_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned AW       = 9,
  parameter int unsigned AF_LEVEL = (1 << AW) - 4,
  parameter int unsigned AE_LEVEL = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  rewind_fifo_if.slave  bus
);

  localparam int unsigned DEPTH = fifo_depth(AW);

  logic [AW:0]  r_wrPtr;
  logic [AW:0]  r_rdPtr;
  logic [AW:0]  r_markPtr;
  logic         r_markValid;
  logic         r_overflow;
  logic         r_underflow;

  logic [31:0]  w_usedCnt;
  logic [31:0]  w_spanCnt;
  logic [AW:0]  w_basePtr;
  logic         w_empty;
  logic         w_full;
  logic         w_rewindGo;
  logic         w_rdGo;
  logic         w_wrGo;
  logic         w_ovfEvent;
  logic         w_udfEvent;

  // Full is measured from the mark while one is held, so marked data is never overwritten.
  assign w_basePtr = r_markValid ? r_markPtr : r_rdPtr;
  assign w_usedCnt = fifo_count(32'(r_wrPtr), 32'(r_rdPtr), AW);
  assign w_spanCnt = fifo_count(32'(r_wrPtr), 32'(w_basePtr), AW);
  assign w_empty   = (w_usedCnt == 32'd0);
  assign w_full    = (w_spanCnt == DEPTH);

  assign w_rewindGo = bus.rewind && r_markValid;
  assign w_rdGo     = bus.rdreq && !w_empty && !w_rewindGo;
  assign w_wrGo     = bus.wrreq && !bus.sclr &&
                      (!w_full || (bus.rdreq && !w_empty && !r_markValid));
  assign w_ovfEvent = bus.wrreq && !w_wrGo;
  assign w_udfEvent = bus.rdreq && w_empty && !w_rewindGo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr     <= '0;
      r_rdPtr     <= '0;
      r_markPtr   <= '0;
      r_markValid <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (bus.sclr) begin
      r_wrPtr     <= '0;
      r_rdPtr     <= '0;
      r_markPtr   <= '0;
      r_markValid <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wrGo) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_rewindGo) begin
        r_rdPtr <= r_markPtr;
      end else begin
        if (w_rdGo) begin
          r_rdPtr <= r_rdPtr + 1'b1;
        end
        if (bus.release_mark) begin
          r_markValid <= 1'b0;
        end else if (bus.mark) begin
          r_markPtr   <= r_rdPtr;
          r_markValid <= 1'b1;
        end
      end
      // An error arriving with clr_err wins, so no event is ever lost.
      r_overflow  <= (r_overflow  && !bus.clr_err) || w_ovfEvent;
      r_underflow <= (r_underflow && !bus.clr_err) || w_udfEvent;
    end
  end

  rewind_fifo_ram #(
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_wrGo),
    .i_waddr (r_wrPtr[AW-1:0]),
    .i_wdata (bus.data),
    .i_raddr (r_rdPtr[AW-1:0]),
    .o_rdata (bus.q)
  );

  assign bus.usedw        = w_usedCnt[AW:0];
  assign bus.empty        = w_empty;
  assign bus.full         = w_full;
  assign bus.almost_empty = (w_usedCnt <= AE_LEVEL);
  assign bus.almost_full  = (w_usedCnt >= AF_LEVEL);
  assign bus.mark_valid   = r_markValid;
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;

endmodule

// File: tb/tb_rewind_fifo.sv
// Directed bench for rewind_fifo (AW=3): reads are scored by a negedge monitor
// against a queue of hand-computed words; flag checks are made inline.
module tb_rewind_fifo;

  logic clk;
  logic rst_n;
  int   nChecks = 0;
  int   nFails  = 0;
  logic [7:0] expQ [$];

  rewind_fifo_if #(.WIDTH(8), .AW(3)) bus ();

  rewind_fifo #(
    .WIDTH    (8),
    .AW       (3),
    .AF_LEVEL (6),
    .AE_LEVEL (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Whenever the DUT pops a word, the head must match the oldest expected word.
  always @(negedge clk) begin
    if (rst_n && bus.rdreq && !bus.empty && !bus.rewind) begin
      if (expQ.size() == 0) begin
        nChecks++;
        nFails++;
        $display("[TB] FAIL read_pop: got 0x%0h, expected no read", bus.q);
      end else begin
        checkOutput("read_q", {24'd0, bus.q}, {24'd0, expQ.pop_front()});
      end
    end
  end

  task automatic applyStimulus(input logic wr, input logic [7:0] d, input logic rd,
                               input logic mk, input logic rw, input logic rel,
                               input logic sc, input logic ce);
    bus.wrreq        = wr;
    bus.data         = d;
    bus.rdreq        = rd;
    bus.mark         = mk;
    bus.rewind       = rw;
    bus.release_mark = rel;
    bus.sclr         = sc;
    bus.clr_err      = ce;
    @(posedge clk);
    #1;
    bus.wrreq        = 1'b0;
    bus.data         = 8'h00;
    bus.rdreq        = 1'b0;
    bus.mark         = 1'b0;
    bus.rewind       = 1'b0;
    bus.release_mark = 1'b0;
    bus.sclr         = 1'b0;
    bus.clr_err      = 1'b0;
  endtask

  task automatic writeWord(input logic [7:0] d);
    applyStimulus(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic readWord(input logic [7:0] exp);
    expQ.push_back(exp);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_usedw"}, 32'(bus.usedw), 32'd0);
    checkOutput({tag, "_empty"}, 32'(bus.empty), 32'd1);
    checkOutput({tag, "_full"}, 32'(bus.full), 32'd0);
    checkOutput({tag, "_ae"}, 32'(bus.almost_empty), 32'd1);
    checkOutput({tag, "_af"}, 32'(bus.almost_full), 32'd0);
    checkOutput({tag, "_markv"}, 32'(bus.mark_valid), 32'd0);
    checkOutput({tag, "_ovf"}, 32'(bus.overflow), 32'd0);
    checkOutput({tag, "_udf"}, 32'(bus.underflow), 32'd0);
  endtask

  // Leaves usedw=5, mark held and overflow set, with three words already popped.
  task automatic buildDirtyState(input logic [7:0] base);
    for (int i = 0; i < 8; i++) writeWord(base + 8'(i));
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) readWord(base + 8'(i));
    writeWord(8'hFF);
    checkOutput("dirty_usedw", 32'(bus.usedw), 32'd5);
    checkOutput("dirty_markv", 32'(bus.mark_valid), 32'd1);
    checkOutput("dirty_ovf", 32'(bus.overflow), 32'd1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    nFails++;
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    bus.wrreq = 1'b0; bus.data = 8'h00; bus.rdreq = 1'b0; bus.mark = 1'b0;
    bus.rewind = 1'b0; bus.release_mark = 1'b0; bus.sclr = 1'b0; bus.clr_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkResetState("reset");
    rst_n = 1'b1;

    // Fill, overflow, drain
    for (int i = 0; i < 8; i++) writeWord(8'h10 + 8'(i));
    checkOutput("fill_full", 32'(bus.full), 32'd1);
    checkOutput("fill_usedw", 32'(bus.usedw), 32'd8);
    writeWord(8'h18);
    checkOutput("fill_ovf", 32'(bus.overflow), 32'd1);
    checkOutput("fill_usedw_after_drop", 32'(bus.usedw), 32'd8);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("clr_err_ovf", 32'(bus.overflow), 32'd0);
    for (int i = 0; i < 8; i++) readWord(8'h10 + 8'(i));
    checkOutput("drain_empty", 32'(bus.empty), 32'd1);
    checkOutput("drain_usedw", 32'(bus.usedw), 32'd0);

    // Thresholds
    writeWord(8'h20); writeWord(8'h21);
    checkOutput("thr_ae_at2", 32'(bus.almost_empty), 32'd1);
    writeWord(8'h22);
    checkOutput("thr_ae_at3", 32'(bus.almost_empty), 32'd0);
    writeWord(8'h23); writeWord(8'h24);
    checkOutput("thr_af_at5", 32'(bus.almost_full), 32'd0);
    writeWord(8'h25);
    checkOutput("thr_af_at6", 32'(bus.almost_full), 32'd1);
    readWord(8'h20);
    checkOutput("thr_af_after_read", 32'(bus.almost_full), 32'd0);
    for (int i = 1; i < 6; i++) readWord(8'h20 + 8'(i));

    // Simultaneous read+write while full
    for (int i = 0; i < 8; i++) writeWord(8'h30 + 8'(i));
    expQ.push_back(8'h30);
    applyStimulus(1'b1, 8'h38, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("simfull_usedw", 32'(bus.usedw), 32'd8);
    checkOutput("simfull_full", 32'(bus.full), 32'd1);
    checkOutput("simfull_ovf", 32'(bus.overflow), 32'd0);
    for (int i = 1; i < 9; i++) readWord(8'h30 + 8'(i));

    // Simultaneous read+write while empty
    applyStimulus(1'b1, 8'h40, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("simempty_udf", 32'(bus.underflow), 32'd1);
    checkOutput("simempty_usedw", 32'(bus.usedw), 32'd1);
    checkOutput("simempty_q", 32'(bus.q), 32'h40);
    readWord(8'h40);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("clr_err_udf", 32'(bus.underflow), 32'd0);

    // Mark / rewind / release
    for (int i = 0; i < 8; i++) writeWord(8'hA0 + 8'(i));
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("mark_valid", 32'(bus.mark_valid), 32'd1);
    for (int i = 0; i < 5; i++) readWord(8'hA0 + 8'(i));
    checkOutput("mark_usedw3", 32'(bus.usedw), 32'd3);
    writeWord(8'hEE);
    checkOutput("mark_write_refused_ovf", 32'(bus.overflow), 32'd1);
    checkOutput("mark_write_refused_usedw", 32'(bus.usedw), 32'd3);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("rewind_q", 32'(bus.q), 32'hA0);
    checkOutput("rewind_usedw", 32'(bus.usedw), 32'd8);
    checkOutput("rewind_keeps_mark", 32'(bus.mark_valid), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("release_markv", 32'(bus.mark_valid), 32'd0);
    readWord(8'hA0); readWord(8'hA1);
    writeWord(8'hB0); writeWord(8'hB1);
    checkOutput("release_usedw", 32'(bus.usedw), 32'd8);
    checkOutput("release_ovf_clear", 32'(bus.overflow), 32'd0);
    for (int i = 2; i < 8; i++) readWord(8'hA0 + 8'(i));
    readWord(8'hB0); readWord(8'hB1);

    // Wrap-around
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 6; i++) writeWord(8'h50 + 8'(r * 6 + i));
      checkOutput("wrap_usedw", 32'(bus.usedw), 32'd6);
      for (int i = 0; i < 6; i++) readWord(8'h50 + 8'(r * 6 + i));
    end
    checkOutput("wrap_empty", 32'(bus.empty), 32'd1);

    // Asynchronous reset mid-operation
    buildDirtyState(8'h60);
    #2 rst_n = 1'b0;
    #1 checkResetState("async");
    #2 rst_n = 1'b1;
    writeWord(8'h70);
    checkOutput("async_next_usedw", 32'(bus.usedw), 32'd1);
    readWord(8'h70);

    // Synchronous clear mid-operation; the concurrent write is suppressed
    buildDirtyState(8'h80);
    applyStimulus(1'b1, 8'hCC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkResetState("sclr");
    writeWord(8'h90);
    readWord(8'h90);

    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("queue_drained", 32'(expQ.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
